// File: rtl/ex_muldiv_unit.sv
// RV32M multiply/divide unit for the EX stage: two-cycle multiply, 32-step restoring
// divide with sign fixup, and a hold_pipeline request that freezes IF/ID/EX meanwhile.
module ex_muldiv_unit #(
  parameter int data_width = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [data_width-1:0] operand_A,
  input  logic [data_width-1:0] operand_B,
  input  logic                  flush,
  output logic                  busy,
  output logic                  result_valid,
  output logic [data_width-1:0] result,
  output logic                  hold_pipeline
);
  localparam int W = data_width;

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIXUP, S_DONE} state_t;

  state_t         state;
  logic [2:0]     op_q;
  logic [W-1:0]   a_q, b_q;
  logic [W-1:0]   quo, rem, dvs, res_q;
  logic [5:0]     cnt;
  logic           qneg, rneg;

  // Operand decode at acceptance; DIV/REM have op[0]=0
  logic           sgn, a_neg, b_neg, b_zero, ovf;
  logic [W-1:0]   abs_a, abs_b, special;
  assign sgn     = ~op[0];
  assign a_neg   = sgn & operand_A[W-1];
  assign b_neg   = sgn & operand_B[W-1];
  assign abs_a   = a_neg ? -operand_A : operand_A;
  assign abs_b   = b_neg ? -operand_B : operand_B;
  assign b_zero  = (operand_B == '0);
  assign ovf     = sgn && (operand_A == {1'b1, {(W-1){1'b0}}}) && (operand_B == '1);
  assign special = b_zero ? (op[1] ? operand_A : '1)
                          : (op[1] ? '0 : {1'b1, {(W-1){1'b0}}});

  // MULH/MULHSU treat rs1 as signed, only MULH treats rs2 as signed
  logic         a_sx, b_sx;
  logic [2*W-1:0] ax, bx, prod;
  assign a_sx = (op_q[1:0] == 2'b01) || (op_q[1:0] == 2'b10);
  assign b_sx = (op_q[1:0] == 2'b01);
  assign ax   = {{W{a_sx & a_q[W-1]}}, a_q};
  assign bx   = {{W{b_sx & b_q[W-1]}}, b_q};
  assign prod = ax * bx;

  // One restoring step: shift in the next dividend bit, subtract if it fits
  logic [W:0]   shifted;
  logic         fits;
  logic [W-1:0] sub;
  assign shifted = {rem, quo[W-1]};
  assign fits    = shifted >= {1'b0, dvs};
  assign sub     = shifted[W-1:0] - dvs;

  assign busy          = (state == S_MUL) || (state == S_DIV) || (state == S_FIXUP);
  assign hold_pipeline = (start && state == S_IDLE && !flush) || busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      quo          <= '0;
      rem          <= '0;
      dvs          <= '0;
      res_q        <= '0;
      cnt          <= '0;
      qneg         <= 1'b0;
      rneg         <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      if (flush) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: if (start) begin
            op_q <= op;
            a_q  <= operand_A;
            b_q  <= operand_B;
            if (!op[2]) begin
              state <= S_MUL;
            end else if (b_zero || ovf) begin
              res_q <= special;
              state <= S_DONE;
            end else begin
              quo   <= abs_a;
              rem   <= '0;
              dvs   <= abs_b;
              cnt   <= '0;
              qneg  <= a_neg ^ b_neg;
              rneg  <= a_neg;
              state <= S_DIV;
            end
          end
          S_MUL: begin
            res_q <= (op_q[1:0] == 2'b00) ? prod[W-1:0] : prod[2*W-1:W];
            state <= S_DONE;
          end
          S_DIV: begin
            rem <= fits ? sub : shifted[W-1:0];
            quo <= {quo[W-2:0], fits};
            cnt <= cnt + 6'd1;
            if (cnt == 6'd31) state <= S_FIXUP;
          end
          S_FIXUP: begin
            res_q <= op_q[1] ? (rneg ? -rem : rem) : (qneg ? -quo : quo);
            state <= S_DONE;
          end
          S_DONE: begin
            result       <= res_q;
            result_valid <= 1'b1;
            state        <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed + randomized bench for ex_muldiv_unit against an arithmetic reference model.
module tb_ex_muldiv_unit;
  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  op;
  logic [31:0] operand_A, operand_B;
  logic        busy, result_valid, hold_pipeline;
  logic [31:0] result;

  int total = 0, passed = 0;

  ex_muldiv_unit #(.data_width(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .operand_A(operand_A), .operand_B(operand_B), .flush(flush),
    .busy(busy), .result_valid(result_valid), .result(result),
    .hold_pipeline(hold_pipeline)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy;
    logic [63:0] p;
    int qi, ri;
    if (!f[2]) begin
      sx = (f == 3'd1 || f == 3'd2) ? longint'($signed(x)) : longint'({32'b0, x});
      sy = (f == 3'd1) ? longint'($signed(y)) : longint'({32'b0, y});
      p  = 64'(sx * sy);
      return (f == 3'd0) ? p[31:0] : p[63:32];
    end
    if (y == 32'd0) return f[1] ? x : 32'hFFFF_FFFF;
    if (!f[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
      return f[1] ? 32'd0 : 32'h8000_0000;
    if (!f[0]) begin
      qi = $signed(x) / $signed(y);
      ri = $signed(x) % $signed(y);
      return f[1] ? ri : qi;
    end
    return f[1] ? (x % y) : (x / y);
  endfunction

  function automatic int lat_of(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    if (!f[2]) return 2;
    if (y == 32'd0 || (!f[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)) return 1;
    return 34;
  endfunction

  // Called at a negedge; returns at the negedge where result_valid is seen.
  // With scramble set, start stays high and operands change while the op runs.
  task automatic run_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                        input bit scramble, input string tag);
    int n, hold_hi, lat;
    logic [31:0] exp;
    exp = model(f, x, y);
    lat = lat_of(f, x, y);
    op = f; operand_A = x; operand_B = y; start = 1'b1;
    #1 chk({tag, "/hold_start"}, 32'(hold_pipeline), 32'd1);
    n = 0; hold_hi = 0;
    while (n < 60) begin
      @(posedge clk); #1;
      if (scramble) begin
        op = 3'($urandom); operand_A = $urandom; operand_B = $urandom;
      end else start = 1'b0;
      n++;
      @(negedge clk);
      if (result_valid) break;
      if (hold_pipeline) hold_hi++;
    end
    start = 1'b0;
    chk({tag, "/latency"}, 32'(n - 1), 32'(lat));
    chk({tag, "/result"}, result, exp);
    chk({tag, "/hold_cycles"}, 32'(hold_hi), 32'(lat - 1));
  endtask

  initial begin
    logic [2:0]  rf;
    logic [31:0] rx, ry, saved;
    int          seen;

    rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; operand_A = '0; operand_B = '0;
    repeat (2) @(negedge clk);
    chk("reset/busy", 32'(busy), 32'd0);
    chk("reset/valid", 32'(result_valid), 32'd0);
    chk("reset/result", result, 32'd0);
    chk("reset/hold", 32'(hold_pipeline), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases, issued back to back from the IDLE after each DONE
    run_op(3'd0, 32'd7, -32'sd3, 1'b0, "mul_7x-3");
    chk("mul_7x-3/const", result, 32'hFFFF_FFEB);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 1'b0, "mulh_min");
    chk("mulh_min/const", result, 32'h4000_0000);
    run_op(3'd3, 32'h8000_0000, 32'h8000_0000, 1'b0, "mulhu_min");
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0, "mulhsu_-1x2");
    chk("mulhsu_-1x2/const", result, 32'hFFFF_FFFF);
    run_op(3'd4, -32'sd7, 32'd2, 1'b0, "div_-7/2");
    chk("div_-7/2/const", result, 32'hFFFF_FFFD);
    run_op(3'd6, -32'sd7, 32'd2, 1'b1, "rem_-7/2");
    run_op(3'd5, 32'd100, 32'd7, 1'b0, "divu_100/7");
    chk("divu_100/7/const", result, 32'd14);
    run_op(3'd7, 32'd100, 32'd7, 1'b0, "remu_100/7");
    run_op(3'd5, 32'd5, 32'd0, 1'b0, "divu_by0");
    run_op(3'd6, 32'd5, 32'd0, 1'b0, "rem_by0");
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "rem_ovf");

    // Randomized operations with a bias toward corner operands
    for (int i = 0; i < 40; i++) begin
      rf = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0: begin rx = 32'h8000_0000; ry = 32'hFFFF_FFFF; end
        1: begin rx = $urandom; ry = 32'd0; end
        2: begin rx = $urandom; ry = 32'($urandom_range(1, 15)); end
        3: begin rx = -32'($urandom_range(0, 1000)); ry = -32'($urandom_range(1, 50)); end
        default: begin rx = $urandom; ry = $urandom; end
      endcase
      run_op(rf, rx, ry, bit'($urandom_range(0, 1)), $sformatf("rand%0d_op%0d", i, rf));
    end

    // Flush mid-divide: unit idles, no strobe, result untouched
    saved = result;
    op = 3'd4; operand_A = -32'sd100; operand_B = 32'd3; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("flush/busy", 32'(busy), 32'd0);
    chk("flush/hold", 32'(hold_pipeline), 32'd0);
    chk("flush/valid", 32'(result_valid), 32'd0);
    flush = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (result_valid) seen++;
    end
    chk("flush/no_strobe", 32'(seen), 32'd0);
    chk("flush/result_kept", result, saved);
    run_op(3'd0, 32'd3, 32'd4, 1'b0, "mul_after_flush");
    chk("mul_after_flush/const", result, 32'd12);

    // Asynchronous reset in the middle of a divide
    op = 3'd5; operand_A = 32'd1000; operand_B = 32'd9; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_mid/busy_before", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid/busy", 32'(busy), 32'd0);
    chk("rst_mid/valid", 32'(result_valid), 32'd0);
    chk("rst_mid/result", result, 32'd0);
    chk("rst_mid/hold", 32'(hold_pipeline), 32'd0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    run_op(3'd5, 32'd1000, 32'd9, 1'b0, "divu_after_rst");

    repeat (3) @(negedge clk);
    chk("end/idle_valid", 32'(result_valid), 32'd0);
    chk("end/idle_busy", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
